// File: rtl/imm_pkg.sv
// Shared types and constants for the RISC-V immediate-generation stage.
package imm_pkg;

  // Output format code of a decoded instruction.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  // Major opcodes (instr[6:0]) the decoder recognises.
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Storage entries are sized for the widest legal configuration so the
  // struct can live in the package; narrower instances use the low bits.
  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 32;

  // One buffered decode result.
  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_e             fmt;
    logic                 illegal;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode_core.sv
// Combinational RISC-V immediate decoder: instruction word -> imm/fmt/illegal.
module imm_decode_core
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit ZICSR = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic signed [31:0] w_raw;   // 32-bit sign-correct immediate before widening
  logic               w_zext;  // CSR immediate: zero-extend rs1 field instead

  // Opcode classification and 32-bit immediate assembly.
  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    w_raw   = '0;
    w_zext  = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        w_raw = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt   = FMT_I;
          w_raw = {{20{instr[31]}}, instr[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        w_raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        w_raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        w_raw = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        w_raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2]=1) carry an immediate.
        if (ZICSR && instr[14]) begin
          fmt    = FMT_Z;
          w_zext = 1'b1;
        end
      end
      OPC_OP, OPC_MISC_MEM: begin
        fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        if (XLEN != 64) illegal = 1'b1;
      end
      // Anything else, including compressed encodings (instr[1:0] != 11).
      default: illegal = 1'b1;
    endcase
  end

  // Widen to XLEN: signed cast sign-extends from instr[31]; CSR uimm zero-extends.
  always_comb begin
    imm = w_zext ? XLEN'(instr[19:15]) : XLEN'(w_raw);
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decoder feeding a 2-entry skid FIFO.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter bit ZICSR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_illegal;
  imm_entry_t      w_entry;
  imm_entry_t      w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_unused_bits;

  imm_entry_t      r_mem [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;

  imm_decode_core #(
    .XLEN  (XLEN),
    .ZICSR (ZICSR)
  ) u_decode (
    .instr   (in_instr),
    .imm     (w_imm),
    .fmt     (w_fmt),
    .illegal (w_illegal)
  );

  // Handshake: ready/valid come from the occupancy register only.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush_i;
  assign w_pop     = out_valid & out_ready;

  // Pack the decode result with its tag for storage.
  always_comb begin
    w_entry         = '0;
    w_entry.imm     = IMM_MAX_W'(w_imm);
    w_entry.fmt     = w_fmt;
    w_entry.illegal = w_illegal;
    w_entry.tag     = TAG_MAX_W'(in_tag);
  end

  // FIFO storage: written at the write pointer on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers and occupancy; flush empties the buffer and drops same-cycle traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry drives the outputs directly.
  assign w_head      = r_mem[r_rd_ptr];
  assign out_imm     = w_head.imm[XLEN-1:0];
  assign out_fmt     = w_head.fmt;
  assign out_illegal = w_head.illegal;
  assign out_tag     = w_head.tag[TAG_W-1:0];

  // High storage bits beyond XLEN/TAG_W are constant zero and never read out.
  assign w_unused_bits = ^w_head;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (RV64, RV32, RV64 without Zicsr).
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  tag32;

  logic        rdynz, vldnz, illnz;
  logic [63:0] immnz;
  logic [2:0]  fmtnz;
  logic [7:0]  tagnz;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(64), .TAG_W(8), .ZICSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64));

  imm_gen_stage #(.XLEN(32), .TAG_W(8), .ZICSR(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32));

  imm_gen_stage #(.XLEN(64), .TAG_W(8), .ZICSR(1'b0)) dutnz (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid(in_valid), .in_ready(rdynz),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vldnz), .out_ready(out_ready),
    .out_imm(immnz), .out_fmt(fmtnz), .out_illegal(illnz), .out_tag(tagnz));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then drop in_valid.
  task automatic push(input logic [31:0] instr, input logic [7:0] tag);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    $display("[TB] push instr=%h tag=%h -> imm64=%h fmt64=%0d ill64=%b imm32=%h fmt32=%0d ill32=%b",
             instr, tag, imm64, fmt64, ill64, imm32, fmt32, ill32);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", 64'(vld64), 64'd0);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_fmt", 64'(fmt64), 64'd0);
    chk("rst_ill", 64'(ill64), 64'd0);
    chk("rst_tag", 64'(tag64), 64'd0);
    chk("rst_ready", 64'(rdy64), 64'd1);
    rst_n = 1'b1;
    tick();

    // addi x1, x0, -1
    push(32'hFFF00093, 8'h01);
    chk("addi_valid", 64'(vld64), 64'd1);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_fmt", 64'(fmt64), 64'd1);
    chk("addi_ill", 64'(ill64), 64'd0);
    chk("addi_tag", 64'(tag64), 64'h01);
    chk("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);

    // beq -4
    push(32'hFE000EE3, 8'h02);
    chk("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_fmt", 64'(fmt64), 64'd3);
    chk("beq_tag", 64'(tag64), 64'h02);

    // lui x1, 0x80000
    push(32'h800000B7, 8'h03);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(imm32), 64'h8000_0000);
    chk("lui_fmt", 64'(fmt64), 64'd4);

    // sw x1, -4(x2)
    push(32'hFE112E23, 8'h04);
    chk("sw_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_fmt", 64'(fmt64), 64'd2);

    // jal x1, +8
    push(32'h008000EF, 8'h05);
    chk("jal_imm", imm64, 64'd8);
    chk("jal_fmt", 64'(fmt64), 64'd5);

    // csrrwi with uimm 0x1F
    push(32'h300FD073, 8'h06);
    chk("csr_imm", imm64, 64'h1F);
    chk("csr_fmt", 64'(fmt64), 64'd6);
    chk("csr_nz_fmt", 64'(fmtnz), 64'd0);
    chk("csr_nz_imm", immnz, 64'd0);
    chk("csr_nz_ill", 64'(illnz), 64'd0);

    // Unknown opcode 1111111
    push(32'h0000007F, 8'h07);
    chk("bad_ill", 64'(ill64), 64'd1);
    chk("bad_imm", imm64, 64'd0);
    chk("bad_fmt", 64'(fmt64), 64'd0);

    // addiw x1, x0, 1
    push(32'h0010009B, 8'h08);
    chk("addiw_fmt64", 64'(fmt64), 64'd1);
    chk("addiw_imm64", imm64, 64'd1);
    chk("addiw_ill64", 64'(ill64), 64'd0);
    chk("addiw_ill32", 64'(ill32), 64'd1);
    chk("addiw_fmt32", 64'(fmt32), 64'd0);
    chk("addiw_imm32", 64'(imm32), 64'd0);

    // add (R-type): no immediate
    push(32'h00000033, 8'h09);
    chk("add_fmt", 64'(fmt64), 64'd0);
    chk("add_ill", 64'(ill64), 64'd0);

    // OP-32 opcode: legal on RV64, illegal on RV32
    push(32'h0000003B, 8'h0A);
    chk("op32_ill64", 64'(ill64), 64'd0);
    chk("op32_ill32", 64'(ill32), 64'd1);

    // Compressed encoding (instr[1:0] != 11)
    push(32'h00000001, 8'h0B);
    chk("rvc_ill", 64'(ill64), 64'd1);

    // Drain
    tick();
    chk("drain_valid", 64'(vld64), 64'd0);

    // Back-pressure: three offers with consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_tag    = 8'hA0;
    tick();
    in_tag = 8'hA1;
    tick();
    in_tag = 8'hA2;
    chk("bp_full_ready", 64'(rdy64), 64'd0);
    tick();
    chk("bp_still_full", 64'(rdy64), 64'd0);
    chk("bp_head0", 64'(tag64), 64'hA0);
    $display("[TB] backpressure full: in_ready=%b head_tag=%h", rdy64, tag64);
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", 64'(rdy64), 64'd1);
    chk("bp_head1", 64'(tag64), 64'hA1);
    tick();
    in_valid = 1'b0;
    chk("bp_head2", 64'(tag64), 64'hA2);
    chk("bp_valid2", 64'(vld64), 64'd1);
    $display("[TB] backpressure release: head_tag=%h valid=%b", tag64, vld64);
    tick();
    chk("bp_empty", 64'(vld64), 64'd0);

    // Flush with a full buffer and a same-cycle offer
    out_ready = 1'b0;
    push(32'h00100093, 8'hB0);
    push(32'h00200093, 8'hB1);
    chk("fl_full", 64'(rdy64), 64'd0);
    in_valid = 1'b1;
    in_tag   = 8'hB2;
    flush_i  = 1'b1;
    tick();
    flush_i  = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(vld64), 64'd0);
    chk("fl_ready", 64'(rdy64), 64'd1);
    tick();
    chk("fl_nosurvive", 64'(vld64), 64'd0);
    $display("[TB] flush: valid=%b ready=%b", vld64, rdy64);

    // Asynchronous reset mid-stream
    push(32'hFFF00093, 8'hC0);
    chk("ar_pre_valid", 64'(vld64), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(vld64), 64'd0);
    chk("ar_imm", imm64, 64'd0);
    chk("ar_tag", 64'(tag64), 64'd0);
    chk("ar_ready", 64'(rdy64), 64'd1);
    $display("[TB] async reset: valid=%b imm=%h", vld64, imm64);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
